// File: rtl/recon_stream_capture.sv
// recon_stream_capture: parses the recon header in beat 0, keeps the slot table, and issues store/load commands.
// Store frames forward the stripped payload with byte-count checking; load and rejected frames are discarded.
module recon_stream_capture #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int ADDR_WIDTH = 34,
  parameter int HDR_OFFSET = 46,
  parameter int NUM_SLOTS = 16,
  parameter int SLOT_SIZE_LOG2 = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH-1:0] m_cmd_addr,
  output logic [31:0]           m_cmd_len,
  output logic [7:0]            m_cmd_id,
  output logic                  m_cmd_valid,
  input  logic                  m_cmd_ready,
  output logic [ADDR_WIDTH-1:0] m_load_addr,
  output logic [31:0]           m_load_len,
  output logic [7:0]            m_load_id,
  output logic                  m_load_valid,
  input  logic                  m_load_ready,
  output logic                  status_good_frame,
  output logic                  status_bad_frame,
  output logic                  status_drop
);
  localparam int PW = $clog2(KEEP_WIDTH) + 1;
  localparam int IW = $clog2(NUM_SLOTS);
  localparam int RB = HDR_OFFSET + 8;
  typedef enum logic [2:0] {IDLE, DEC, CMD, FIRST, PAYLOAD, DONE, LOAD, DROP} state_t;
  state_t state, state_n;
  logic [1:0] func;
  logic [7:0] id;
  logic size_valid;
  logic [31:0] size;
  logic [DATA_WIDTH-1:0] rem_data;
  logic [KEEP_WIDTH-1:0] rem_keep;
  logic rem_last;
  logic [PW-1:0] rem_cnt;
  logic [PW-1:0] beat_cnt;
  logic [31:0] remaining;
  logic bad;
  logic [NUM_SLOTS-1:0] tbl_valid;
  logic [31:0] tbl_size [NUM_SLOTS];
  logic [IW-1:0] idx;
  logic id_ok, store_ok, load_ok, rem_over, beat_over, out_hs;

  function automatic logic [PW-1:0] popcount(input logic [KEEP_WIDTH-1:0] k);
    popcount = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) popcount = popcount + PW'(k[i]);
  endfunction

  assign idx = id[IW-1:0];
  assign id_ok = 32'(id) < NUM_SLOTS;
  assign store_ok = func == 2'b00 && size_valid && id_ok && {1'b0, size} <= (33'd1 << SLOT_SIZE_LOG2);
  assign load_ok = func == 2'b01 && id_ok && tbl_valid[idx];
  assign beat_cnt = popcount(s_axis_tkeep);
  assign rem_over = 32'(rem_cnt) > size;
  assign beat_over = 32'(beat_cnt) > remaining;
  assign out_hs = s_axis_tvalid && m_axis_tready;
  assign m_cmd_addr = ADDR_WIDTH'(idx) << SLOT_SIZE_LOG2;
  assign m_cmd_len = size;
  assign m_cmd_id = id;
  assign m_load_addr = ADDR_WIDTH'(idx) << SLOT_SIZE_LOG2;
  assign m_load_len = tbl_size[idx];
  assign m_load_id = id;

  always_comb begin
    state_n = state;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata = rem_data;
    m_axis_tkeep = rem_keep;
    m_axis_tlast = rem_last;
    m_axis_tuser = 1'b0;
    m_cmd_valid = 1'b0;
    m_load_valid = 1'b0;
    status_good_frame = 1'b0;
    status_bad_frame = 1'b0;
    status_drop = 1'b0;
    case (state)
      IDLE: begin
        s_axis_tready = 1'b1;
        state_n = s_axis_tvalid ? DEC : IDLE;
      end
      DEC: begin
        status_drop = !store_ok && !load_ok;
        state_n = store_ok ? CMD : load_ok ? LOAD : rem_last ? IDLE : DROP;
      end
      CMD: begin
        m_cmd_valid = 1'b1;
        state_n = m_cmd_ready ? FIRST : CMD;
      end
      FIRST: begin
        // an empty remnant is only emitted when it has to carry tlast
        m_axis_tvalid = rem_last || |rem_keep;
        m_axis_tuser = rem_last && 32'(rem_cnt) != size;
        state_n = !m_axis_tvalid ? PAYLOAD : !m_axis_tready ? FIRST : rem_last ? DONE : PAYLOAD;
      end
      PAYLOAD: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata = s_axis_tdata;
        m_axis_tkeep = s_axis_tkeep;
        m_axis_tlast = s_axis_tlast;
        m_axis_tuser = s_axis_tlast && (bad || remaining != 32'(beat_cnt));
        state_n = out_hs && s_axis_tlast ? DONE : PAYLOAD;
      end
      DONE: begin
        status_good_frame = !bad;
        status_bad_frame = bad;
        state_n = IDLE;
      end
      LOAD: begin
        m_load_valid = 1'b1;
        state_n = !m_load_ready ? LOAD : rem_last ? IDLE : DROP;
      end
      DROP: begin
        s_axis_tready = 1'b1;
        state_n = s_axis_tvalid && s_axis_tlast ? IDLE : DROP;
      end
      default: state_n = IDLE;
    endcase
    if (rst) begin
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tuser = 1'b0;
      m_cmd_valid = 1'b0;
      m_load_valid = 1'b0;
      status_good_frame = 1'b0;
      status_bad_frame = 1'b0;
      status_drop = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tbl_valid <= '0;
      bad <= 1'b0;
      remaining <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && s_axis_tvalid) begin
        func <= s_axis_tdata[8*HDR_OFFSET +: 2];
        id <= s_axis_tdata[8*HDR_OFFSET+2 +: 8];
        size_valid <= s_axis_tdata[8*HDR_OFFSET+31];
        size <= s_axis_tdata[8*HDR_OFFSET+32 +: 32];
        rem_data <= s_axis_tdata >> (8*RB);
        rem_keep <= s_axis_tkeep >> RB;
        rem_last <= s_axis_tlast;
        rem_cnt <= popcount(s_axis_tkeep >> RB);
        bad <= 1'b0;
      end
      if (state == DEC && store_ok) begin
        tbl_valid[idx] <= 1'b1;
        tbl_size[idx] <= size;
      end
      if (state == FIRST && state_n != FIRST) begin
        remaining <= rem_over ? '0 : size - 32'(rem_cnt);
        bad <= rem_over || (rem_last && 32'(rem_cnt) != size);
      end
      if (state == PAYLOAD && out_hs) begin
        remaining <= beat_over ? '0 : remaining - 32'(beat_cnt);
        bad <= bad || beat_over || (s_axis_tlast && remaining != 32'(beat_cnt));
      end
      if (state == DONE) bad <= 1'b0;
    end
  end
endmodule
